// File: rtl/cic_comb_decimator.sv
// -----------------------------------------------------------------------------
// cic_comb_decimator
//
// Comb half of a 3rd-order CIC decimation filter. The upstream three-stage
// integrator delivers a WIDTH-bit running sum (modular). This block keeps
// one sample in every RATE accepted samples and passes it through three
// cascaded first-order differentiators. It emits one result per decimated
// sample, accompanied by a single-cycle valid strobe.
//
// All arithmetic is modulo 2^WIDTH. CIC filters depend on wrap-around, so
// there is no saturation and no overflow flag.
//
// Parameters:
//   WIDTH  data width of input, comb delay registers and output
//   RATE   decimation factor, 1..256
//
// Ports:
//   clock      in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high reset (overrides in_valid)
//   in_data    in   WIDTH  integrator output sample
//   in_valid   in   1      in_data holds a new sample this cycle
//   out_data   out  WIDTH  comb-filtered decimated result
//   out_valid  out  1      one-cycle strobe, out_data updated this cycle
//
// Optional build macro:
//   CIC_COMB_FILL_MASK_EN  When defined, out_valid is suppressed for the
//                          first three decimated results after reset. Those
//                          results are comb pipeline fill. out_data and the
//                          delay registers update as normal.
// -----------------------------------------------------------------------------
module cic_comb_decimator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATE  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  // A one-bit counter still exists when RATE=1. It then stays at 0, and
  // every valid sample strobes.
  localparam int unsigned          PHASE_W    = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(RATE - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [WIDTH-1:0]   z1_q, z1_d;
  logic [WIDTH-1:0]   z2_q, z2_d;
  logic [WIDTH-1:0]   z3_q, z3_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               strb;
  logic [WIDTH-1:0]   y1, y2, y3;

`ifdef CIC_COMB_FILL_MASK_EN
  logic [1:0]         fill_q, fill_d;
`endif

  // Decimation phase and strobe
  always_comb begin
    strb    = in_valid && (phase_q == PHASE_LAST);
    phase_d = phase_q;
    if (in_valid) begin
      if (phase_q == PHASE_LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Comb cascade: each section subtracts its own delayed input, which is the
  // previous decimated sample seen by that section.
  always_comb begin
    y1 = in_data - z1_q;
    y2 = y1 - z2_q;
    y3 = y2 - z3_q;
  end

  always_comb begin
    z1_d       = z1_q;
    z2_d       = z2_q;
    z3_d       = z3_q;
    out_data_d = out_data_q;
    if (strb) begin
      z1_d       = in_data;
      z2_d       = y1;
      z3_d       = y2;
      out_data_d = y3;
    end
  end

`ifdef CIC_COMB_FILL_MASK_EN
  // The fill counter saturates at 3. Only strobes seen after three earlier
  // strobes produce a visible valid.
  always_comb begin
    fill_d = fill_q;
    if (strb && (fill_q != 2'd3)) begin
      fill_d = fill_q + 2'd1;
    end
    out_valid_d = strb && (fill_q == 2'd3);
  end
`else
  always_comb begin
    out_valid_d = strb;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      z3_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      z3_q        <= z3_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CIC_COMB_FILL_MASK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q <= 2'd0;
    end else begin
      fill_q <= fill_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
module tb_cic_comb_decimator;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // RATE=4 instance
  logic       rst4, vld4;
  logic [7:0] din4, dout4;
  logic       vout4;

  // RATE=1 instance
  logic       rst1, vld1;
  logic [7:0] din1, dout1;
  logic       vout1;

  cic_comb_decimator #(.WIDTH(8), .RATE(4)) dut4 (
    .clock(clock), .reset(rst4), .in_data(din4), .in_valid(vld4),
    .out_data(dout4), .out_valid(vout4));

  cic_comb_decimator #(.WIDTH(8), .RATE(1)) dut1 (
    .clock(clock), .reset(rst1), .in_data(din1), .in_valid(vld1),
    .out_data(dout1), .out_valid(vout1));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  // With the fill mask, the first three strobes after reset are hidden.
  function automatic logic visible(input int k);
`ifdef CIC_COMB_FILL_MASK_EN
    return (k >= 3);
`else
    return 1'b1;
`endif
  endfunction

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt[$];
  logic [7:0] tbl_last_d;
  int         tbl_k;

  // One table row. raw_v/raw_d give the unmasked strobe result from the
  // expected sequences, and non-strobe rows hold the previous output.
  task automatic push(input logic r, input logic v, input logic [7:0] d,
                      input logic raw_v, input logic [7:0] raw_d);
    vec_t e;
    e.rst = r; e.vld = v; e.data = d;
    if (r) begin
      tbl_last_d = 8'd0; tbl_k = 0; e.exp_v = 1'b0;
    end else if (raw_v) begin
      tbl_last_d = raw_d; e.exp_v = visible(tbl_k); tbl_k++;
    end else begin
      e.exp_v = 1'b0;
    end
    e.exp_d = tbl_last_d;
    vt.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] ramp_out [5];
    logic [7:0] const_out[4];
    logic [7:0] r1_out   [4];
    logic [7:0] h[3];
    logic       ev;
    logic [7:0] ed;
    int         cnt, k;

    ramp_out  = '{8'd3, 8'd254, 8'd255, 8'd0, 8'd0};
    const_out = '{8'd200, 8'd112, 8'd200, 8'd0};

    // Ramp 0..19
    push(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      push(0, 1, 8'(i), (i % 4) == 3, ramp_out[i / 4]);
    // Constant 200 with modular wrap
    push(1, 1, 8'd99, 0, 0);
    for (int i = 0; i < 16; i++)
      push(0, 1, 8'd200, (i % 4) == 3, const_out[(i / 4) > 3 ? 3 : i / 4]);
    // Gapped valid: only the 4th accepted sample strobes
    push(1, 0, 0, 0, 0);
    push(0, 1, 8'd10, 0, 0);
    push(0, 0, 8'd77, 0, 0);
    push(0, 1, 8'd20, 0, 0);
    push(0, 0, 8'd78, 0, 0);
    push(0, 0, 8'd79, 0, 0);
    push(0, 1, 8'd30, 0, 0);
    push(0, 1, 8'd40, 1, 8'd40);
    push(0, 0, 8'd80, 0, 0);
    // Reset in mid-ramp, then restart
    push(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      push(0, 1, 8'(i), (i % 4) == 3, ramp_out[i / 4]);
    push(1, 1, 8'd10, 0, 0);
    for (int i = 0; i < 16; i++)
      push(0, 1, 8'(i), (i % 4) == 3, ramp_out[i / 4]);

    rst4 = 1'b1; vld4 = 1'b0; din4 = 8'd0;
    rst1 = 1'b1; vld1 = 1'b0; din1 = 8'd0;
    tick();
    check("reset_valid", 0, {7'd0, vout4}, 8'd0);
    check("reset_data",  0, dout4, 8'd0);

    foreach (vt[i]) begin
      rst4 = vt[i].rst; vld4 = vt[i].vld; din4 = vt[i].data;
      tick();
      check("vec_valid", i, {7'd0, vout4}, {7'd0, vt[i].exp_v});
      check("vec_data",  i, dout4, vt[i].exp_d);
    end

    // RATE=1: every valid sample strobes. The third difference of a step of 5
    // is 5, -10, 5, 0 (mod 256).
    r1_out = '{8'd5, 8'd246, 8'd5, 8'd0};
    rst1 = 1'b0; vld1 = 1'b1; din1 = 8'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r1_valid", i, {7'd0, vout1}, {7'd0, visible(i)});
      check("r1_data",  i, dout1, r1_out[i]);
    end
    vld1 = 1'b0; din1 = 8'd33;
    tick();
    check("r1_idle_valid", 0, {7'd0, vout1}, 8'd0);
    check("r1_idle_data",  0, dout1, 8'd0);

    // Randomized run on RATE=4. The reference is the closed-form third
    // difference of the decimated sequence.
    rst4 = 1'b1; vld4 = 1'b0;
    tick();
    cnt = 0; k = 0; h = '{8'd0, 8'd0, 8'd0}; ed = 8'd0; ev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst4 = ($urandom_range(0, 79) == 0);
      vld4 = ($urandom_range(0, 9) < 7);
      din4 = 8'($urandom);
      if (rst4) begin
        cnt = 0; k = 0; h = '{8'd0, 8'd0, 8'd0}; ed = 8'd0; ev = 1'b0;
      end else if (vld4) begin
        if ((cnt % 4) == 3) begin
          ed = 8'(int'(din4) - 3 * int'(h[0]) + 3 * int'(h[1]) - int'(h[2]));
          h[2] = h[1]; h[1] = h[0]; h[0] = din4;
          ev = visible(k);
          k++;
        end else begin
          ev = 1'b0;
        end
        cnt++;
      end else begin
        ev = 1'b0;
      end
      tick();
      check("rnd_valid", c, {7'd0, vout4}, {7'd0, ev});
      check("rnd_data",  c, dout4, ed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
